// File: rtl/combo_pkg.sv
// combo_pkg: shared definitions for the combination dialer.
//   state_t    - dialer mode (IDLE, PROG, SEND, DONE)
//   SEG_*      - active-low seven-segment patterns, bit order {g,f,e,d,c,b,a}
//   seg7()     - BCD digit to segment pattern, blank for values above 9
package combo_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PROG = 2'd1,
    SEND = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0011000;
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_P     = 7'b0001100;
  localparam logic [6:0] SEG_D     = 7'b0100001;

  function automatic logic [6:0] seg7(input logic [3:0] val);
    logic [6:0] s;
    case (val)
      4'd0:    s = SEG_0;
      4'd1:    s = SEG_1;
      4'd2:    s = SEG_2;
      4'd3:    s = SEG_3;
      4'd4:    s = SEG_4;
      4'd5:    s = SEG_5;
      4'd6:    s = SEG_6;
      4'd7:    s = SEG_7;
      4'd8:    s = SEG_8;
      4'd9:    s = SEG_9;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/seg7_decoder.sv
// seg7_decoder: combinational BCD to active-low seven-segment decoder.
//   digit - 4-bit value to display
//   seg   - active-low segments {g..a}; blank for values above 9
module seg7_decoder
  import combo_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = seg7(digit);
  end

endmodule

// File: rtl/combo_dialer.sv
// combo_dialer: holds a CODE_LEN-digit combination and plays it back one
// digit per step strobe, zero-extended to the 10-bit form the lock samples.
//   clk, rst               - clock, synchronous active-high reset
//   prog_start             - enter programming mode (restarts at position 0)
//   digit_in, digit_we     - digit to program and its write strobe
//   start, step            - begin playback / advance to the next digit
//   digit_out, digit_valid - current code digit and its qualifier
//   busy, done             - activity and playback-complete flags
//   prog_done, err         - one-cycle pulses: last digit written / bad digit
//   hex0, hex1             - active-low displays: digit, and position or mode
module combo_dialer
  import combo_pkg::*;
#(
  parameter int                      CODE_LEN     = 6,
  parameter logic [CODE_LEN*4-1:0]   DEFAULT_CODE = {4'd6, 4'd3, 4'd2, 4'd9, 4'd1, 4'd4}
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       prog_start,
  input  logic [3:0] digit_in,
  input  logic       digit_we,
  input  logic       start,
  input  logic       step,
  output logic [9:0] digit_out,
  output logic       digit_valid,
  output logic       busy,
  output logic       done,
  output logic       prog_done,
  output logic       err,
  output logic [6:0] hex0,
  output logic [6:0] hex1
);

  localparam int               IDX_W = (CODE_LEN > 1) ? $clog2(CODE_LEN) : 1;
  localparam logic [IDX_W-1:0] LAST  = IDX_W'(CODE_LEN - 1);

  state_t           state, state_n;
  logic [IDX_W-1:0] idx, idx_n, wr_ptr, wr_ptr_n;
  logic [3:0]       code [CODE_LEN];
  logic             code_we, done_n, prog_done_n, err_n, valid_n;
  logic [3:0]       digit_n, pos_n;
  logic [6:0]       seg_digit, seg_pos;

  // Stage: next-state decode
  always_comb begin
    state_n     = state;
    idx_n       = idx;
    wr_ptr_n    = wr_ptr;
    done_n      = done;
    prog_done_n = 1'b0;
    err_n       = 1'b0;
    code_we     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (prog_start) begin
          state_n  = PROG;
          wr_ptr_n = '0;
          done_n   = 1'b0;
        end else if (start) begin
          state_n = SEND;
          idx_n   = '0;
          done_n  = 1'b0;
        end
      end
      PROG: begin
        if (prog_start) begin
          wr_ptr_n = '0;
        end else if (digit_we) begin
          if (digit_in > 4'd9) begin
            err_n = 1'b1;
          end else begin
            code_we = 1'b1;
            if (wr_ptr == LAST) begin
              state_n     = IDLE;
              wr_ptr_n    = '0;
              prog_done_n = 1'b1;
            end else begin
              wr_ptr_n = wr_ptr + 1'b1;
            end
          end
        end
      end
      SEND: begin
        if (start) begin
          idx_n = '0;
        end else if (step) begin
          if (idx == LAST) begin
            state_n = DONE;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // digit_out keeps its last value whenever no digit is being presented
    valid_n = (state_n == SEND);
    digit_n = valid_n ? code[idx_n] : digit_out[3:0];
    pos_n   = 4'(idx_n) + 4'd1;
  end

  seg7_decoder u_seg_digit (.digit(digit_n), .seg(seg_digit));
  seg7_decoder u_seg_pos   (.digit(pos_n),   .seg(seg_pos));

  // Stage: state and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      idx         <= '0;
      wr_ptr      <= '0;
      for (int i = 0; i < CODE_LEN; i++) begin
        // element 0 sits in the most significant nibble of DEFAULT_CODE
        code[i] <= DEFAULT_CODE[(CODE_LEN-1-i)*4 +: 4];
      end
      digit_out   <= '0;
      digit_valid <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      prog_done   <= 1'b0;
      err         <= 1'b0;
      hex0        <= SEG_BLANK;
      hex1        <= SEG_BLANK;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      wr_ptr <= wr_ptr_n;
      if (code_we) begin
        code[wr_ptr] <= digit_in;
      end
      digit_out   <= {6'b0, digit_n};
      digit_valid <= valid_n;
      busy        <= (state_n == PROG) || (state_n == SEND);
      done        <= done_n;
      prog_done   <= prog_done_n;
      err         <= err_n;
      hex0        <= valid_n ? seg_digit : SEG_BLANK;
      case (state_n)
        SEND:    hex1 <= seg_pos;
        PROG:    hex1 <= SEG_P;
        DONE:    hex1 <= SEG_D;
        default: hex1 <= SEG_BLANK;
      endcase
    end
  end

endmodule

// File: tb/tb_combo_dialer.sv
module tb_combo_dialer;

  logic       clk = 1'b0;
  logic       rst, prog_start, digit_we, start, step;
  logic [3:0] digit_in;
  logic [9:0] digit_out;
  logic       digit_valid, busy, done, prog_done, err;
  logic [6:0] hex0, hex1;

  always #5 clk = ~clk;

  combo_dialer dut (
    .clk(clk), .rst(rst), .prog_start(prog_start), .digit_in(digit_in),
    .digit_we(digit_we), .start(start), .step(step), .digit_out(digit_out),
    .digit_valid(digit_valid), .busy(busy), .done(done), .prog_done(prog_done),
    .err(err), .hex0(hex0), .hex1(hex1)
  );

  int errors = 0;
  int checks = 0;

  localparam logic [6:0] BLK = 7'h7F;
  localparam logic [6:0] SP  = 7'b0001100;
  localparam logic [6:0] SD  = 7'b0100001;

  function automatic logic [6:0] seg(input int v);
    case (v)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0011000;
      default: return 7'h7F;
    endcase
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural reference: a list of digits, a mode, a read and a write position.
  int  m_code [6];
  int  m_mode;          // 0 idle, 1 programming, 2 sending, 3 finished
  int  m_pos, m_wp, m_dout;
  bit  m_done, m_pd, m_err;

  task automatic model_reset();
    m_code = '{6, 3, 2, 9, 1, 4};
    m_mode = 0; m_pos = 0; m_wp = 0; m_dout = 0;
    m_done = 0; m_pd = 0; m_err = 0;
  endtask

  task automatic model_step(input bit r, input bit ps, input int din, input bit we,
                            input bit st, input bit stp);
    m_pd = 0; m_err = 0;
    if (r) begin
      model_reset();
      return;
    end
    if (m_mode == 0 || m_mode == 3) begin
      if (ps) begin m_mode = 1; m_wp = 0; m_done = 0; end
      else if (st) begin m_mode = 2; m_pos = 0; m_done = 0; end
    end else if (m_mode == 1) begin
      if (ps) m_wp = 0;
      else if (we) begin
        if (din > 9) m_err = 1;
        else begin
          m_code[m_wp] = din;
          m_wp++;
          if (m_wp == 6) begin m_mode = 0; m_pd = 1; end
        end
      end
    end else begin
      if (st) m_pos = 0;
      else if (stp) begin
        if (m_pos + 1 == 6) begin m_mode = 3; m_done = 1; end
        else m_pos++;
      end
    end
    if (m_mode == 2) m_dout = m_code[m_pos];
  endtask

  task automatic cyc(input logic r, input logic ps, input logic [3:0] din,
                     input logic we, input logic st, input logic stp);
    rst = r; prog_start = ps; digit_in = din; digit_we = we; start = st; step = stp;
    @(posedge clk);
    model_step(r, ps, int'(din), we, st, stp);
    #1;
    rst = 0; prog_start = 0; digit_we = 0; start = 0; step = 0;
  endtask

  typedef struct {
    logic       ps;
    logic [3:0] din;
    logic       we, st, stp;
    logic       ev;
    logic [3:0] ed;
    logic       edone, epd, eerr, ebusy;
    logic [6:0] eh1;
  } vec_t;

  function automatic vec_t mk(input logic ps, input logic [3:0] din, input logic we,
                              input logic st, input logic stp, input logic ev,
                              input logic [3:0] ed, input logic edone, input logic epd,
                              input logic eerr, input logic ebusy, input logic [6:0] eh1);
    vec_t v;
    v.ps = ps; v.din = din; v.we = we; v.st = st; v.stp = stp; v.ev = ev; v.ed = ed;
    v.edone = edone; v.epd = epd; v.eerr = eerr; v.ebusy = ebusy; v.eh1 = eh1;
    return v;
  endfunction

  vec_t tv [23];

  initial begin
    rst = 1; prog_start = 0; digit_in = 0; digit_we = 0; start = 0; step = 0;

    //              ps din   we st stp  ev ed  done pd err busy hex1
    tv[0]  = mk(0, 4'd0, 0, 1, 0,   1, 6,  0, 0, 0, 1, seg(1));
    tv[1]  = mk(0, 4'd0, 0, 0, 1,   1, 3,  0, 0, 0, 1, seg(2));
    tv[2]  = mk(0, 4'd0, 0, 0, 1,   1, 2,  0, 0, 0, 1, seg(3));
    tv[3]  = mk(0, 4'd0, 0, 0, 1,   1, 9,  0, 0, 0, 1, seg(4));
    tv[4]  = mk(0, 4'd0, 0, 0, 1,   1, 1,  0, 0, 0, 1, seg(5));
    tv[5]  = mk(0, 4'd0, 0, 0, 1,   1, 4,  0, 0, 0, 1, seg(6));
    tv[6]  = mk(0, 4'd0, 0, 0, 1,   0, 0,  1, 0, 0, 0, SD);
    tv[7]  = mk(1, 4'd0, 0, 0, 0,   0, 0,  0, 0, 0, 1, SP);
    tv[8]  = mk(0, 4'd1, 1, 0, 0,   0, 0,  0, 0, 0, 1, SP);
    tv[9]  = mk(0, 4'd2, 1, 0, 0,   0, 0,  0, 0, 0, 1, SP);
    tv[10] = mk(0, 4'd12,1, 0, 0,   0, 0,  0, 0, 1, 1, SP);
    tv[11] = mk(0, 4'd3, 1, 0, 0,   0, 0,  0, 0, 0, 1, SP);
    tv[12] = mk(0, 4'd4, 1, 0, 1,   0, 0,  0, 0, 0, 1, SP);
    tv[13] = mk(0, 4'd5, 1, 1, 0,   0, 0,  0, 0, 0, 1, SP);
    tv[14] = mk(0, 4'd6, 1, 0, 0,   0, 0,  0, 1, 0, 0, BLK);
    tv[15] = mk(0, 4'd0, 0, 0, 0,   0, 0,  0, 0, 0, 0, BLK);
    tv[16] = mk(0, 4'd0, 0, 1, 0,   1, 1,  0, 0, 0, 1, seg(1));
    tv[17] = mk(0, 4'd0, 0, 0, 1,   1, 2,  0, 0, 0, 1, seg(2));
    tv[18] = mk(0, 4'd0, 0, 0, 1,   1, 3,  0, 0, 0, 1, seg(3));
    tv[19] = mk(0, 4'd0, 0, 0, 1,   1, 4,  0, 0, 0, 1, seg(4));
    tv[20] = mk(0, 4'd0, 0, 0, 1,   1, 5,  0, 0, 0, 1, seg(5));
    tv[21] = mk(0, 4'd0, 0, 0, 1,   1, 6,  0, 0, 0, 1, seg(6));
    tv[22] = mk(0, 4'd0, 0, 0, 1,   0, 0,  1, 0, 0, 0, SD);

    // reset state
    cyc(1, 0, 0, 0, 0, 0);
    chk("rst_digit_out", 32'(digit_out), 0);
    chk("rst_valid", 32'(digit_valid), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_prog_done", 32'(prog_done), 0);
    chk("rst_err", 32'(err), 0);
    chk("rst_hex0", 32'(hex0), 32'(BLK));
    chk("rst_hex1", 32'(hex1), 32'(BLK));

    // table: default playback, programming with a rejected digit, new playback
    for (int i = 0; i < 23; i++) begin
      cyc(0, tv[i].ps, tv[i].din, tv[i].we, tv[i].st, tv[i].stp);
      chk($sformatf("v%0d_valid", i), 32'(digit_valid), 32'(tv[i].ev));
      if (tv[i].ev) chk($sformatf("v%0d_digit", i), 32'(digit_out), 32'(tv[i].ed));
      chk($sformatf("v%0d_done", i), 32'(done), 32'(tv[i].edone));
      chk($sformatf("v%0d_prog_done", i), 32'(prog_done), 32'(tv[i].epd));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tv[i].eerr));
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(tv[i].ebusy));
      chk($sformatf("v%0d_hex1", i), 32'(hex1), 32'(tv[i].eh1));
      chk($sformatf("v%0d_hex0", i), 32'(hex0), 32'(tv[i].ev ? seg(int'(tv[i].ed)) : BLK));
    end

    // reset in the middle of playing a programmed code restores the default code
    cyc(0, 0, 0, 0, 1, 0);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("mid_digit_idx3", 32'(digit_out), 4);
    cyc(1, 0, 0, 0, 0, 1);
    chk("mid_rst_valid", 32'(digit_valid), 0);
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_hex1", 32'(hex1), 32'(BLK));
    chk("mid_rst_digit", 32'(digit_out), 0);
    cyc(0, 0, 0, 0, 1, 0);
    chk("after_rst_digit", 32'(digit_out), 6);
    chk("after_rst_valid", 32'(digit_valid), 1);
    cyc(0, 0, 0, 0, 0, 1);
    chk("after_rst_digit2", 32'(digit_out), 3);

    // prog_start and start together: programming wins, step and start ignored
    cyc(1, 0, 0, 0, 0, 0);
    cyc(0, 1, 0, 0, 1, 0);
    chk("both_busy", 32'(busy), 1);
    chk("both_hex1", 32'(hex1), 32'(SP));
    chk("both_valid", 32'(digit_valid), 0);
    cyc(0, 0, 0, 0, 0, 1);
    chk("both_step_valid", 32'(digit_valid), 0);
    chk("both_step_hex1", 32'(hex1), 32'(SP));
    cyc(0, 0, 0, 0, 1, 0);
    chk("both_start_hex1", 32'(hex1), 32'(SP));
    // rejected digit leaves the write position alone: 7 becomes the first digit
    cyc(0, 0, 4'd12, 1, 0, 0);
    chk("err_pulse", 32'(err), 1);
    cyc(0, 0, 4'd7, 1, 0, 0);
    chk("err_one_cycle", 32'(err), 0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 4'(i), 1, 0, 0);
    chk("prog7_done", 32'(prog_done), 1);
    cyc(0, 0, 0, 0, 1, 0);
    chk("prog7_first", 32'(digit_out), 7);

    // randomized run against the reference model
    cyc(1, 0, 0, 0, 0, 0);
    for (int n = 0; n < 800; n++) begin
      logic r, ps, we, st, stp;
      logic [3:0] din;
      r   = ($urandom_range(0, 79) == 0);
      ps  = ($urandom_range(0, 19) == 0);
      st  = ($urandom_range(0, 11) == 0);
      stp = ($urandom_range(0, 1) == 0);
      we  = ($urandom_range(0, 1) == 0);
      din = ($urandom_range(0, 5) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      cyc(r, ps, din, we, st, stp);
      chk("rnd_valid", 32'(digit_valid), 32'(m_mode == 2));
      chk("rnd_digit", 32'(digit_out), 32'(m_dout));
      chk("rnd_busy", 32'(busy), 32'(m_mode == 1 || m_mode == 2));
      chk("rnd_done", 32'(done), 32'(m_done));
      chk("rnd_prog_done", 32'(prog_done), 32'(m_pd));
      chk("rnd_err", 32'(err), 32'(m_err));
      chk("rnd_hex0", 32'(hex0), 32'(m_mode == 2 ? seg(m_code[m_pos]) : BLK));
      chk("rnd_hex1", 32'(hex1), 32'(m_mode == 2 ? seg(m_pos + 1) :
                                     m_mode == 1 ? SP : m_mode == 3 ? SD : BLK));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
